match_filter_mt: RTL and testbench

- Parametrised successor to the single-config QPSK correlator in the inband receive path.
- Correlates the complex rx sample stream against a loadable ±1±j code of up to TAPS chips, using a time-multiplexed LANES-wide adder tree.
- Outputs an approximate magnitude, a threshold match and match hold-off per strobe.
- Flags strobe overruns.
- Sits between the rx strobe source and the inband packet/timestamp logic.

---
 rtl/match_filter_mt.sv | 255 +++++++++++++++++++++++++
 tb/tb_match_filter_mt.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_filter_mt.sv
`default_nettype none
// ==== match_filter_mt : ±1±j code correlator, LANES-wide time-multiplexed tree, magnitude/threshold/hold-off
// ==== Rev 1.0
module match_filter_mt #(
  parameter int WIDTH = 16,
  parameter int TAPS  = 192,
  parameter int LANES = 64,
  parameter int ACCW  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [WIDTH-1:0] r_input,
  input  logic signed [WIDTH-1:0] i_input,
  input  logic                    rxstrobe,
  input  logic [31:0]             cdata,
  input  logic [7:0]              caddr,
  input  logic                    cwrite,
  output logic                    valid,
  output logic                    match,
  output logic [ACCW-1:0]         magnitude,
  output logic                    busy,
  output logic                    overrun,
  output logic [15:0]             debugbus
);
  localparam int P     = TAPS / LANES;
  localparam int NPASS = 2 * P;
  localparam int GRP   = LANES / 8;
  localparam int NCW   = TAPS / 16;
  localparam int TW    = WIDTH + 1;
  localparam int LENW  = 9;
  localparam int BW    = (P > 1) ? $clog2(P) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [4:0]              pass_q, pass_d;
  logic signed [WIDTH-1:0] xr_q [TAPS];
  logic signed [WIDTH-1:0] xi_q [TAPS];
  logic [2*TAPS-1:0]       coef_q;
  logic [LENW-1:0]         len_q;
  logic [ACCW-1:0]         thr_q;
  logic [15:0]             holdoff_q, hold_q, hold_d;
  logic                    enable_q, overrun_q, overrun_d;
  logic                    start, shift, issue;
  logic [BW-1:0]           blk;

  logic signed [TW-1:0]    sel_d [LANES];
  logic signed [TW-1:0]    sel_q [LANES];
  logic                    sel_v_q, sel_im_q, sel_last_q;
  logic signed [ACCW-1:0]  s8_d [GRP];
  logic signed [ACCW-1:0]  s8_q [GRP];
  logic                    s8_v_q, s8_im_q, s8_last_q;
  logic signed [ACCW-1:0]  sum_d, sum_q;
  logic                    sum_v_q, sum_im_q, sum_last_q;
  logic signed [ACCW-1:0]  re_acc_q, im_acc_q;
  logic                    acc_done_q;
  logic [ACCW-1:0]         a_q, b_q, mx, mn, mag_d, mag_q;
  logic [ACCW:0]           mag_sum;
  logic                    abs_v_q, valid_q, match_q, match_d, raw;

  function automatic logic signed [TW-1:0] tap_term(
    input logic signed [WIDTH-1:0] xr, input logic signed [WIDTH-1:0] xi,
    input logic cr, input logic ci, input logic im);
    logic signed [TW-1:0] er, ei, ta, tb;
    er = TW'(xr);
    ei = TW'(xi);
    // conj(code)*x : re = xr*cr + xi*ci, im = xi*cr - xr*ci
    if (!im) begin
      ta = cr ? er : -er;
      tb = ci ? ei : -ei;
    end else begin
      ta = cr ? ei : -ei;
      tb = ci ? -er : er;
    end
    return ta + tb;
  endfunction

  function automatic logic [ACCW-1:0] abs_sat(input logic signed [ACCW-1:0] v);
    if (v == {1'b1, {(ACCW-1){1'b0}}}) return {1'b0, {(ACCW-1){1'b1}}};
    return v[ACCW-1] ? ACCW'(-v) : ACCW'(v);
  endfunction

  assign busy  = (state_q != S_IDLE);
  assign issue = (state_q == S_ISSUE);
  assign shift = rxstrobe && !busy;
  assign start = shift && enable_q && !cwrite;
  assign blk   = pass_q[BW:1];

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE:  if (start) begin
                 state_d = S_ISSUE;
                 pass_d  = '0;
               end
      S_ISSUE: if (pass_q == 5'(NPASS - 1)) state_d = S_DRAIN;
               else pass_d = pass_q + 5'd1;
      S_DRAIN: if (valid_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    overrun_d = overrun_q;
    if (cwrite && caddr == 8'd3 && cdata[0]) overrun_d = 1'b0;
    if (rxstrobe && busy) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coef_q    <= '0;
      len_q     <= LENW'(TAPS);
      thr_q     <= '1;
      holdoff_q <= '0;
      enable_q  <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      if (cwrite) begin
        if (caddr == 8'd0) len_q <= {1'b0, cdata[7:0]};
        if (caddr == 8'd1) thr_q <= ACCW'(cdata);
        if (caddr == 8'd2) holdoff_q <= cdata[15:0];
        if (caddr == 8'd3) enable_q <= cdata[1];
        for (int k = 0; k < NCW; k++)
          if (caddr == 8'(4 + k)) coef_q[32*k +: 32] <= cdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < TAPS; n++) begin
        xr_q[n] <= '0;
        xi_q[n] <= '0;
      end
    end else if (shift) begin
      xr_q[0] <= r_input;
      xi_q[0] <= i_input;
      for (int n = 1; n < TAPS; n++) begin
        xr_q[n] <= xr_q[n-1];
        xi_q[n] <= xi_q[n-1];
      end
    end
  end

  // Each lane picks its tap from the block addressed by the current pass.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic signed [TW-1:0] opt [P];
    for (genvar b = 0; b < P; b++) begin : g_blk
      localparam int N = b * LANES + l;
      assign opt[b] = (LENW'(N) < len_q) ?
                      tap_term(xr_q[N], xi_q[N], coef_q[2*N+1], coef_q[2*N], pass_q[0]) : '0;
    end
    assign sel_d[l] = opt[blk];
  end

  always_comb begin
    for (int g = 0; g < GRP; g++) begin
      s8_d[g] = '0;
      for (int j = 0; j < 8; j++) s8_d[g] = s8_d[g] + ACCW'(sel_q[8*g+j]);
    end
    sum_d = '0;
    for (int g = 0; g < GRP; g++) sum_d = sum_d + s8_q[g];
  end

  assign mx      = (a_q > b_q) ? a_q : b_q;
  assign mn      = (a_q > b_q) ? b_q : a_q;
  assign mag_sum = {1'b0, mx} + {2'b00, mn[ACCW-1:1]};
  assign mag_d   = mag_sum[ACCW] ? '1 : mag_sum[ACCW-1:0];
  assign raw     = mag_d > thr_q;

  always_comb begin
    match_d = match_q;
    hold_d  = hold_q;
    if (abs_v_q) begin
      if (hold_q != '0) begin
        match_d = 1'b0;
        hold_d  = hold_q - 16'd1;
      end else begin
        match_d = raw;
        if (raw) hold_d = holdoff_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l < LANES; l++) sel_q[l] <= '0;
      for (int g = 0; g < GRP; g++) s8_q[g] <= '0;
      {sel_v_q, sel_im_q, sel_last_q} <= '0;
      {s8_v_q, s8_im_q, s8_last_q}    <= '0;
      {sum_v_q, sum_im_q, sum_last_q} <= '0;
      sum_q      <= '0;
      re_acc_q   <= '0;
      im_acc_q   <= '0;
      acc_done_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      abs_v_q    <= 1'b0;
      valid_q    <= 1'b0;
      match_q    <= 1'b0;
      mag_q      <= '0;
      hold_q     <= '0;
    end else begin
      sel_q      <= sel_d;
      sel_v_q    <= issue;
      sel_im_q   <= pass_q[0];
      sel_last_q <= (pass_q == 5'(NPASS - 1));
      s8_q       <= s8_d;
      s8_v_q     <= sel_v_q;
      s8_im_q    <= sel_im_q;
      s8_last_q  <= sel_last_q;
      sum_q      <= sum_d;
      sum_v_q    <= s8_v_q;
      sum_im_q   <= s8_im_q;
      sum_last_q <= s8_last_q;
      if (start) begin
        re_acc_q <= '0;
        im_acc_q <= '0;
      end else if (sum_v_q) begin
        if (sum_im_q) im_acc_q <= im_acc_q + sum_q;
        else          re_acc_q <= re_acc_q + sum_q;
      end
      acc_done_q <= sum_v_q && sum_last_q;
      if (acc_done_q) begin
        a_q <= abs_sat(re_acc_q);
        b_q <= abs_sat(im_acc_q);
      end
      abs_v_q <= acc_done_q;
      valid_q <= abs_v_q;
      if (abs_v_q) mag_q <= mag_d;
      match_q <= match_d;
      hold_q  <= hold_d;
    end
  end

  assign valid     = valid_q;
  assign match     = match_q;
  assign magnitude = mag_q;
  assign overrun   = overrun_q;
  assign debugbus  = {match_q, valid_q, busy, overrun_q, enable_q, pass_q,
                      issue, sel_v_q, s8_v_q, sum_v_q, acc_done_q, abs_v_q};
endmodule
`default_nettype wire

// File: tb/tb_match_filter_mt.sv
`default_nettype none
// ==== tb_match_filter_mt : table, directed and random checks against a behavioural correlator model
// ==== Rev 1.0
module tb_match_filter_mt;
  localparam int WIDTH = 16;
  localparam int TAPS  = 192;
  localparam int LANES = 64;
  localparam int ACCW  = 32;
  localparam int LAT   = 2 * (TAPS / LANES) + 5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [WIDTH-1:0]  r_input = '0, i_input = '0;
  logic              rxstrobe = 1'b0, cwrite = 1'b0;
  logic [31:0]       cdata = '0;
  logic [7:0]        caddr = '0;
  logic              valid, match, busy, overrun;
  logic [ACCW-1:0]   magnitude;
  logic [15:0]       debugbus;

  match_filter_mt #(.WIDTH(WIDTH), .TAPS(TAPS), .LANES(LANES), .ACCW(ACCW)) dut (
    .clk(clk), .reset(reset), .r_input(r_input), .i_input(i_input),
    .rxstrobe(rxstrobe), .cdata(cdata), .caddr(caddr), .cwrite(cwrite),
    .valid(valid), .match(match), .magnitude(magnitude), .busy(busy),
    .overrun(overrun), .debugbus(debugbus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  int          mxr [TAPS];
  int          mxi [TAPS];
  bit          mcr [TAPS];
  bit          mci [TAPS];
  int          mlen, mholdoff, mhold;
  logic [31:0] mthr;
  bit          movr;

  typedef struct {
    logic [15:0] r;
    logic [15:0] i;
    logic [31:0] mag;
    logic        m;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int n = 0; n < TAPS; n++) begin
      mxr[n] = 0; mxi[n] = 0; mcr[n] = 0; mci[n] = 0;
    end
    mlen = TAPS; mthr = '1; mholdoff = 0; mhold = 0; movr = 0;
  endtask

  task automatic model_shift(input logic [15:0] r, input logic [15:0] i);
    for (int n = TAPS - 1; n > 0; n--) begin
      mxr[n] = mxr[n-1];
      mxi[n] = mxi[n-1];
    end
    mxr[0] = int'($signed(r));
    mxi[0] = int'($signed(i));
  endtask

  function automatic longint abs_sat(input logic signed [31:0] v);
    longint x;
    x = longint'(v);
    if (x < 0) x = -x;
    if (x > 64'sd2147483647) x = 64'sd2147483647;
    return x;
  endfunction

  // Correlation from the arithmetic definition: per-tap 17-bit products, 32-bit wrapping sums.
  function automatic logic [31:0] model_mag();
    logic signed [31:0] re, im;
    logic [16:0]        t;
    int                 pr, pi, sr, si;
    longint             a, b, m;
    re = 0; im = 0;
    for (int n = 0; n < TAPS && n < mlen; n++) begin
      sr = mcr[n] ? 1 : -1;
      si = mci[n] ? 1 : -1;
      pr = sr * mxr[n] + si * mxi[n];
      pi = sr * mxi[n] - si * mxr[n];
      t = pr[16:0]; re = re + {{15{t[16]}}, t};
      t = pi[16:0]; im = im + {{15{t[16]}}, t};
    end
    a = abs_sat(re);
    b = abs_sat(im);
    m = (a > b) ? a + b / 2 : b + a / 2;
    if (m > 64'sd4294967295) m = 64'sd4294967295;
    return m[31:0];
  endfunction

  function automatic logic model_match(input logic [31:0] mag);
    logic r;
    r = mag > mthr;
    if (mhold != 0) begin
      mhold = mhold - 1;
      return 1'b0;
    end
    if (r) mhold = mholdoff;
    return r;
  endfunction

  task automatic cfg(input logic [7:0] a, input logic [31:0] d);
    int k;
    caddr = a; cdata = d; cwrite = 1'b1;
    tick();
    cwrite = 1'b0;
    k = int'(a) - 4;
    if (a == 8'd0) mlen = int'(d[7:0]);
    else if (a == 8'd1) mthr = d;
    else if (a == 8'd2) mholdoff = int'(d[15:0]);
    else if (a == 8'd3) begin
      if (d[0]) movr = 0;
    end else if (k >= 0 && k < TAPS / 16) begin
      for (int j = 0; j < 16; j++) begin
        mcr[16*k+j] = d[2*j+1];
        mci[16*k+j] = d[2*j];
      end
    end
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    model_reset();
  endtask

  // One start strobe, optional overlapping strobe at cycle 'inject', full result check.
  task automatic do_start(input logic [15:0] r, input logic [15:0] i, input int inject,
                          output logic [31:0] gm, output logic gx);
    logic [31:0] emag;
    bit          early;
    model_shift(r, i);
    emag = model_mag();
    r_input = r; i_input = i; rxstrobe = 1'b1;
    tick();
    rxstrobe = 1'b0;
    chk("busy_after_start", busy, 1);
    early = 0;
    for (int k = 1; k <= LAT; k++) begin
      if (k == inject) begin
        r_input = 16'($urandom); i_input = 16'($urandom); rxstrobe = 1'b1;
      end
      tick();
      rxstrobe = 1'b0;
      if (k == inject) movr = 1;
      if (k < LAT && valid) early = 1;
    end
    chk("valid_not_early", early, 0);
    chk("valid_at_latency", valid, 1);
    chk("magnitude", magnitude, emag);
    chk("match", match, model_match(emag));
    chk("overrun", overrun, movr);
    gm = magnitude;
    gx = match;
    tick();
    chk("valid_one_cycle", valid, 0);
    chk("busy_released", busy, 0);
    chk("magnitude_held", magnitude, emag);
  endtask

  task automatic expect_no_valid(input string nm, input int cycles);
    bit seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (valid) seen = 1;
    end
    chk(nm, seen, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] gm;
    logic        gx;
    vec_t        t2 [6];
    logic        pat3 [6];
    int          lens [8];

    t2[0] = '{16'd10, 16'd10, 32'd20, 1'b0};
    t2[1] = '{16'd10, 16'd10, 32'd40, 1'b0};
    t2[2] = '{16'd10, 16'd10, 32'd60, 1'b1};
    t2[3] = '{16'd10, 16'd10, 32'd80, 1'b1};
    t2[4] = '{16'd10, 16'd10, 32'd80, 1'b1};
    t2[5] = '{16'd10, 16'd10, 32'd80, 1'b1};
    pat3  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    lens  = '{0, 1, 37, 63, 64, 65, 192, 200};

    // Reset state
    do_reset();
    chk("rst_valid", valid, 0);
    chk("rst_match", match, 0);
    chk("rst_magnitude", magnitude, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);

    // Impulse against an all-(+1+j) code
    for (int k = 0; k < TAPS / 16; k++) cfg(8'(4 + k), 32'hFFFF_FFFF);
    cfg(8'd1, 32'd149);
    do_start(16'd100, 16'd0, -1, gm, gx);
    chk("t1_mag", gm, 150);
    chk("t1_match", gx, 1);
    for (int k = 0; k < 2; k++) begin
      do_start(16'd0, 16'd0, -1, gm, gx);
      chk("t1_mag_hold", gm, 150);
    end
    cfg(8'd1, 32'd150);
    do_start(16'd0, 16'd0, -1, gm, gx);
    chk("t1_strict_threshold", gx, 0);

    // Short code length fills then saturates
    do_reset();
    for (int k = 0; k < TAPS / 16; k++) cfg(8'(4 + k), 32'hFFFF_FFFF);
    cfg(8'd0, 32'd4);
    cfg(8'd1, 32'd50);
    for (int v = 0; v < 6; v++) begin
      do_start(t2[v].r, t2[v].i, -1, gm, gx);
      chk("t2_mag", gm, t2[v].mag);
      chk("t2_match", gx, t2[v].m);
    end

    // Hold-off pattern
    do_reset();
    cfg(8'd2, 32'd2);
    cfg(8'd1, 32'd0);
    for (int v = 0; v < 6; v++) begin
      do_start(16'(v + 1), 16'd3, -1, gm, gx);
      chk("t3_holdoff", gx, pat3[v]);
    end

    // Overrun, sticky, clear; enable gating
    do_reset();
    do_start(16'd1000, 16'hFE0C, 5, gm, gx);
    do_start(16'd7, 16'd7, -1, gm, gx);
    chk("t4_overrun_sticky", overrun, 1);
    cfg(8'd3, 32'd3);
    chk("t4_overrun_clear", overrun, 0);
    cfg(8'd3, 32'd0);
    r_input = 16'd321; i_input = 16'd123; rxstrobe = 1'b1;
    tick();
    rxstrobe = 1'b0;
    model_shift(16'd321, 16'd123);
    chk("t4_disabled_busy", busy, 0);
    expect_no_valid("t4_disabled_no_valid", LAT + 3);
    cfg(8'd3, 32'd2);
    do_start(16'd5, 16'd9, -1, gm, gx);

    // Strobe coincident with a config write
    do_reset();
    for (int k = 0; k < TAPS / 16; k++) cfg(8'(4 + k), 32'hFFFF_FFFF);
    cfg(8'd0, 32'd2);
    r_input = 16'd50; i_input = 16'd0; rxstrobe = 1'b1;
    caddr = 8'hFF; cdata = 32'h0; cwrite = 1'b1;
    tick();
    rxstrobe = 1'b0; cwrite = 1'b0;
    model_shift(16'd50, 16'd0);
    expect_no_valid("t5_no_valid", LAT + 3);
    do_start(16'd0, 16'd0, -1, gm, gx);
    chk("t5_includes_shifted", gm, 75);

    // Asynchronous reset mid-computation
    do_reset();
    cfg(8'd1, 32'd0);
    do_start(16'd300, 16'd0, -1, gm, gx);
    r_input = 16'd400; rxstrobe = 1'b1;
    tick();
    rxstrobe = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("t6_busy_before", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_valid_async", valid, 0);
    chk("t6_busy_async", busy, 0);
    chk("t6_mag_async", magnitude, 0);
    chk("t6_match_async", match, 0);
    model_reset();
    tick();
    #2 reset = 1'b1;
    expect_no_valid("t6_no_valid_after", LAT + 4);
    do_start(16'd1000, 16'd1000, -1, gm, gx);
    chk("t6_default_threshold", gx, 0);

    // Randomised configurations and samples
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < TAPS / 16; k++) cfg(8'(4 + k), $urandom);
      cfg(8'd0, 32'(lens[c]));
      cfg(8'd1, 32'($urandom_range(0, 32'h0040_0000)));
      cfg(8'd2, 32'($urandom_range(0, 2)));
      for (int s = 0; s < 8; s++) begin
        do_start(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), -1, gm, gx);
        if (lens[c] == 0) chk("rand_len0_mag", gm, 0);
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
